// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-port signals shared by the memory port arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           m_ready, m_rvalid, m_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           m_ready, m_rvalid, m_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction in flight, data first.
// Define MEM_ARB_FAIRNESS_EN to force a fetch grant after MAX_DATA_STREAK data grants while fetch waits.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              protocol_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      r_state;
  logic        r_owner_d;
  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_wstrb;
  logic        r_if_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_err;

  logic w_arb;
  logic w_force_f;
  logic w_gnt_d;
  logic w_gnt_f;
  logic w_accept;

  // A new grant may be made while idle or in the very cycle the previous response lands.
  assign w_arb = (r_state == IDLE) || ((r_state == WAIT) && bus.m_rvalid);

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] r_streak;

  assign w_force_f = bus.if_req && (r_streak == 4'(MAX_DATA_STREAK));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_arb && w_gnt_d) begin
      r_streak <= bus.if_req ? r_streak + 4'd1 : 4'd0;
    end else if (w_arb && w_gnt_f) begin
      r_streak <= '0;
    end
  end
`else
  assign w_force_f = 1'b0;
`endif

  assign w_gnt_d  = bus.d_req && !w_force_f;
  assign w_gnt_f  = bus.if_req && !w_gnt_d;
  assign w_accept = (r_state == ISSUE) && bus.m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner_d   <= 1'b0;
      r_m_req     <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_m_wstrb   <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (bus.m_rvalid && (r_state != WAIT)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ISSUE: begin
          if (bus.m_ready) begin
            r_state <= WAIT;
            r_m_req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.m_rvalid) begin
            if (r_owner_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= bus.m_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.m_rdata;
            end
          end
        end
        default: ;
      endcase
      // Arbitration overrides the WAIT hold above so a response and the next grant share a cycle.
      if (w_arb) begin
        if (w_gnt_d || w_gnt_f) begin
          r_state   <= ISSUE;
          r_m_req   <= 1'b1;
          r_owner_d <= w_gnt_d;
          r_m_we    <= w_gnt_d && bus.d_we;
          r_m_addr  <= w_gnt_d ? bus.d_addr : bus.if_addr;
          r_m_wdata <= (w_gnt_d && bus.d_we) ? bus.d_wdata : 32'h0;
          r_m_wstrb <= (w_gnt_d && bus.d_we) ? bus.d_wstrb : 4'h0;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.m_req     = r_m_req;
  assign bus.m_we      = r_m_we;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.m_wstrb   = r_m_wstrb;
  assign bus.if_ready  = w_accept && !r_owner_d;
  assign bus.d_ready   = w_accept && r_owner_d;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign busy          = (r_state != IDLE);
  assign protocol_err  = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic protocol_err;
  int   vectors = 0;
  int   errors  = 0;
  bit   gq[$];                          // grant owners in order, 1 = data
  logic [31:0] mem_model [logic [31:0]];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs();
    next_cycle(); next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    next_cycle(); next_cycle();
    #4;
    vectors++;
    if ({bus.m_req, bus.m_we, bus.if_ready, bus.d_ready, bus.if_rvalid, bus.d_rvalid, busy, protocol_err} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {bus.m_req, bus.m_we, bus.if_ready, bus.d_ready, bus.if_rvalid, bus.d_rvalid, busy, protocol_err});
    end
    vectors++;
    if ({bus.m_addr, bus.m_wdata, bus.m_wstrb} !== 68'h0) begin
      errors++; $display("FAIL reset_mbus: got %h %h %h expected zeros", bus.m_addr, bus.m_wdata, bus.m_wstrb);
    end
    vectors++;
    if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h %h expected zeros", bus.if_rdata, bus.d_rdata);
    end
    bus.if_req = 1; bus.d_req = 1; bus.m_ready = 1;
    next_cycle(); #4;
    vectors++;
    if (bus.m_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got m_req=%b busy=%b expected 0 0", bus.m_req, busy);
    end
    reset = 0; clear_inputs();
    next_cycle();
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h100; bus.m_ready = 1;
    #4;
    vectors++;
    if (bus.if_ready !== 1'b0 || bus.m_req !== 1'b0) begin
      errors++; $display("FAIL fetch_c0: got if_ready=%b m_req=%b expected 0 0", bus.if_ready, bus.m_req);
    end
    next_cycle(); #4;
    vectors++;
    if (bus.m_req !== 1'b1 || bus.if_ready !== 1'b1 || bus.m_addr !== 32'h100 || bus.m_we !== 1'b0) begin
      errors++; $display("FAIL fetch_c1: got m_req=%b if_ready=%b m_addr=%h m_we=%b expected 1 1 00000100 0",
                         bus.m_req, bus.if_ready, bus.m_addr, bus.m_we);
    end
    next_cycle();
    bus.if_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h00500093;
    #4;
    vectors++;
    if (bus.m_req !== 1'b0 || bus.if_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_c2: got m_req=%b if_rvalid=%b expected 0 0", bus.m_req, bus.if_rvalid);
    end
    next_cycle();
    bus.m_rvalid = 0;
    #4;
    vectors++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00500093 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_c3: got if_rvalid=%b if_rdata=%h d_rvalid=%b expected 1 00500093 0",
                         bus.if_rvalid, bus.if_rdata, bus.d_rvalid);
    end
    next_cycle(); #4;
    vectors++;
    if (bus.if_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fetch_c4: got if_rvalid=%b busy=%b expected 0 0", bus.if_rvalid, busy);
    end
    next_cycle();
  endtask

  task automatic test_store_load();
    logic [31:0] word;
    do_reset();
    word = 32'h0;
    for (int i = 0; i < 2; i++) begin
      bus.d_req = 1; bus.d_we = (i == 0); bus.d_addr = 32'h2000;
      bus.d_wdata = (i == 0) ? 32'hDEADBEEF : 32'h12345678; bus.d_wstrb = 4'hF; bus.m_ready = 1;
      next_cycle(); #4;
      vectors++;
      if (bus.d_ready !== 1'b1 || bus.m_addr !== 32'h2000 || bus.m_we !== (i == 0)) begin
        errors++; $display("FAIL sl_issue%0d: got d_ready=%b m_addr=%h m_we=%b", i, bus.d_ready, bus.m_addr, bus.m_we);
      end
      vectors++;
      if (bus.m_wstrb !== ((i == 0) ? 4'hF : 4'h0) || bus.m_wdata !== ((i == 0) ? 32'hDEADBEEF : 32'h0)) begin
        errors++; $display("FAIL sl_payload%0d: got wstrb=%b wdata=%h", i, bus.m_wstrb, bus.m_wdata);
      end
      if (bus.m_we) word = bus.m_wdata;
      next_cycle();
      bus.d_req = 0; bus.m_rvalid = 1; bus.m_rdata = word;
      next_cycle();
      bus.m_rvalid = 0;
      #4;
      vectors++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF || bus.if_rvalid !== 1'b0) begin
        errors++; $display("FAIL sl_resp%0d: got d_rvalid=%b d_rdata=%h expected 1 deadbeef", i, bus.d_rvalid, bus.d_rdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h140; bus.d_req = 1; bus.d_addr = 32'h2080; bus.m_ready = 1;
    next_cycle(); #4;
    vectors++;
    if (bus.d_ready !== 1'b1 || bus.if_ready !== 1'b0 || bus.m_addr !== 32'h2080) begin
      errors++; $display("FAIL cont_data: got d_ready=%b if_ready=%b m_addr=%h expected 1 0 00002080",
                         bus.d_ready, bus.if_ready, bus.m_addr);
    end
    next_cycle();
    bus.d_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h11;
    next_cycle();
    bus.m_rvalid = 0;
    #4;
    vectors++;
    if (bus.d_rvalid !== 1'b1 || bus.if_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.m_addr !== 32'h140) begin
      errors++; $display("FAIL cont_fetch: got d_rvalid=%b if_ready=%b d_ready=%b m_addr=%h expected 1 1 0 00000140",
                         bus.d_rvalid, bus.if_ready, bus.d_ready, bus.m_addr);
    end
    next_cycle();
    bus.if_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h22;
    next_cycle();
    bus.m_rvalid = 0;
    #4;
    vectors++;
    if (bus.if_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.if_rdata !== 32'h22) begin
      errors++; $display("FAIL cont_resp: got if_rvalid=%b d_rvalid=%b if_rdata=%h expected 1 0 00000022",
                         bus.if_rvalid, bus.d_rvalid, bus.if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2040; bus.m_ready = 0;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      #4;
      vectors++;
      if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h2040 || bus.d_ready !== 1'b0 || bus.if_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got m_req=%b m_addr=%h d_ready=%b expected 1 00002040 0",
                           i, bus.m_req, bus.m_addr, bus.d_ready);
      end
      next_cycle();
    end
    bus.m_ready = 1;
    #4;
    vectors++;
    if (bus.d_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got d_ready=%b expected 1", bus.d_ready);
    end
    next_cycle();
    bus.d_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hA5A50001;
    next_cycle();
    bus.m_rvalid = 0;
    #4;
    vectors++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA5A50001) begin
      errors++; $display("FAIL bp_resp: got d_rvalid=%b d_rdata=%h expected 1 a5a50001", bus.d_rvalid, bus.d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_error_reset();
    do_reset();
    bus.m_rvalid = 1; bus.m_rdata = 32'h5;
    next_cycle();
    bus.m_rvalid = 0;
    #4;
    vectors++;
    if (protocol_err !== 1'b1 || bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL err_set: got protocol_err=%b if_rvalid=%b d_rvalid=%b expected 1 0 0",
                         protocol_err, bus.if_rvalid, bus.d_rvalid);
    end
    repeat (3) next_cycle();
    #4;
    vectors++;
    if (protocol_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b expected 1", protocol_err);
    end
    next_cycle();
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h180; bus.m_ready = 1;
    next_cycle();
    next_cycle();
    bus.if_req = 0; reset = 1;
    next_cycle();
    reset = 0;
    #4;
    vectors++;
    if ({busy, bus.m_req, bus.if_ready, bus.if_rvalid, protocol_err} !== 5'b0 || bus.m_addr !== 32'h0) begin
      errors++; $display("FAIL rst_wait: got busy=%b m_req=%b if_rvalid=%b err=%b m_addr=%h expected zeros",
                         busy, bus.m_req, bus.if_rvalid, protocol_err, bus.m_addr);
    end
    next_cycle();
    bus.m_rvalid = 1; bus.m_rdata = 32'h77;
    next_cycle();
    bus.m_rvalid = 0;
    #4;
    vectors++;
    if (protocol_err !== 1'b1 || bus.if_rvalid !== 1'b0) begin
      errors++; $display("FAIL late_rvalid: got protocol_err=%b if_rvalid=%b expected 1 0", protocol_err, bus.if_rvalid);
    end
    next_cycle();
  endtask

  // Random requesters and memory; model checks grant choice, payload, ready, response and error state.
  task automatic run_traffic(input int ncyc, input int pf, input int pd, input int prdy, input int maxdly);
    bit f_pend, d_pend, dwe, out, due, due_d, iss, iss_d, exp_d, got_d, pf_prev, pd_prev, mreq_prev;
    logic [31:0] fa, da, dwd, resp, due_dat, key, tmp;
    logic [3:0]  dws;
    logic [1:0]  exp_rdy;
    int dly, streak, grants, resps, cyc;
    f_pend = 0; d_pend = 0; dwe = 0; out = 0; due = 0; due_d = 0; iss = 0; iss_d = 0;
    pf_prev = 0; pd_prev = 0; mreq_prev = 0;
    fa = 0; da = 0; dwd = 0; dws = 0; resp = 0; due_dat = 0;
    dly = 0; streak = 0; grants = 0; resps = 0; cyc = 0;
    gq.delete();
    mem_model.delete();
    do_reset();
    while (cyc < ncyc || f_pend || d_pend || out || due) begin
      if (cyc > ncyc + 400) begin
        errors++; $display("FAIL drain_timeout: pending f=%b d=%b out=%b expected all clear", f_pend, d_pend, out);
        break;
      end
      if (!f_pend && cyc < ncyc && $urandom_range(99) < pf) begin
        f_pend = 1; fa = 32'h100 + 32'($urandom_range(15)) * 4;
      end
      if (!d_pend && cyc < ncyc && $urandom_range(99) < pd) begin
        d_pend = 1; dwe = 1'($urandom_range(1)); da = 32'h2000 + 32'($urandom_range(15)) * 4;
        dwd = $urandom; dws = 4'($urandom_range(15));
      end
      bus.if_req = f_pend; bus.if_addr = fa;
      bus.d_req = d_pend; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd; bus.d_wstrb = dws;
      bus.m_ready = ($urandom_range(99) < prdy);
      if (out && dly == 0) begin
        bus.m_rvalid = 1; bus.m_rdata = resp; out = 0;
      end else begin
        bus.m_rvalid = 0; bus.m_rdata = $urandom;
        if (out) dly--;
      end
      #4;
      vectors++;
      if (due) begin
        if ({bus.if_rvalid, bus.d_rvalid} !== (due_d ? 2'b01 : 2'b10)
            || (due_d ? bus.d_rdata : bus.if_rdata) !== due_dat) begin
          errors++; $display("FAIL resp cyc%0d: got if_rv=%b d_rv=%b if_rd=%h d_rd=%h expected owner_d=%b data %h",
                             cyc, bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata, due_d, due_dat);
        end else resps++;
      end else if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
        errors++; $display("FAIL spurious_rvalid cyc%0d: got %b %b expected 0 0", cyc, bus.if_rvalid, bus.d_rvalid);
      end
      if (!iss && bus.m_req === 1'b1) begin
        exp_d = pd_prev && !(FAIR && pf_prev && streak == MAXS);
        got_d = bus.m_addr[13];
        gq.push_back(got_d);
        vectors++;
        if (mreq_prev || got_d !== exp_d || !(exp_d ? pd_prev : pf_prev)) begin
          errors++; $display("FAIL grant cyc%0d: got data=%b (m_req_prev=%b) expected data=%b (f=%b d=%b streak=%0d)",
                             cyc, got_d, mreq_prev, exp_d, pf_prev, pd_prev, streak);
        end
        streak = (got_d && pf_prev) ? streak + 1 : 0;
        iss = 1; iss_d = got_d;
      end else if (iss && bus.m_req !== 1'b1) begin
        errors++; $display("FAIL m_req_drop cyc%0d: got %b expected 1", cyc, bus.m_req);
        iss = 0;
      end
      if (iss) begin
        vectors++;
        if (bus.m_addr !== (iss_d ? da : fa) || bus.m_we !== (iss_d & dwe)
            || bus.m_wstrb !== ((iss_d && dwe) ? dws : 4'h0) || bus.m_wdata !== ((iss_d && dwe) ? dwd : 32'h0)) begin
          errors++; $display("FAIL payload cyc%0d: got addr=%h we=%b strb=%b wdata=%h owner_d=%b",
                             cyc, bus.m_addr, bus.m_we, bus.m_wstrb, bus.m_wdata, iss_d);
        end
      end
      exp_rdy = (iss && bus.m_ready) ? (iss_d ? 2'b01 : 2'b10) : 2'b00;
      vectors++;
      if ({bus.if_ready, bus.d_ready} !== exp_rdy || protocol_err !== 1'b0) begin
        errors++; $display("FAIL ready cyc%0d: got if_ready=%b d_ready=%b err=%b expected %b err 0",
                           cyc, bus.if_ready, bus.d_ready, protocol_err, exp_rdy);
      end
      due = bus.m_rvalid; due_d = iss_d; due_dat = bus.m_rdata;
      pf_prev = f_pend; pd_prev = d_pend; mreq_prev = bus.m_req;
      if (iss && bus.m_ready) begin
        key = iss_d ? da : fa;
        if (!mem_model.exists(key)) mem_model[key] = ~key;
        tmp = mem_model[key];
        if (iss_d && dwe)
          for (int b = 0; b < 4; b++) if (dws[b]) tmp[8*b +: 8] = dwd[8*b +: 8];
        mem_model[key] = tmp;
        resp = tmp; out = 1; dly = int'($urandom_range(maxdly));
        if (iss_d) d_pend = 0; else f_pend = 0;
        iss = 0; grants++;
      end
      next_cycle();
      cyc++;
    end
    clear_inputs();
    vectors++;
    if (resps != grants || grants == 0) begin
      errors++; $display("FAIL txn_count: got %0d responses expected %0d (nonzero)", resps, grants);
    end
  endtask

  task automatic test_random();
    run_traffic(1500, 40, 50, 60, 3);
    run_traffic(800, 80, 80, 90, 1);
  endtask

  task automatic test_fairness();
    bit exp_d;
    run_traffic(60, 100, 100, 100, 0);
    vectors++;
    if (gq.size() < 10) begin
      errors++; $display("FAIL fair_count: got %0d grants expected at least 10", gq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp_d = FAIR ? (i % (MAXS + 1) != MAXS) : 1'b1;
        vectors++;
        if (gq[i] !== exp_d) begin
          errors++; $display("FAIL fair_seq%0d: got data=%b expected data=%b", i, gq[i], exp_d);
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_backpressure();
    test_error_reset();
    test_fairness();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch stage and the data (load/store) path of the three-stage RV32 pipeline.
- Accepts one request at a time from either side and drives it onto the memory port. Tracks exactly one outstanding transaction and returns the response to its owner.
- Data requests have priority over fetch, with an optional starvation guard.
- Sits between the pipeline top level and the unified memory model.

Parameters:
- MAX_DATA_STREAK, 4, number of consecutive data grants allowed while a fetch is pending before fetch is forced (legal 1..15; used only with the guard enabled).

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  32  fetch word address
- if_ready  out  1  fetch request accepted by memory this cycle
- if_rvalid  out  1  one-cycle pulse, fetch data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request; held with payload stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_ready  out  1  data request accepted by memory this cycle
- d_rvalid  out  1  one-cycle pulse, load data valid or store acknowledged
- d_rdata  out  32  load read data
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_wstrb  out  4  memory byte enables (0000 for reads)
- m_ready  in  1  memory accepts request when m_req & m_ready
- m_rvalid  in  1  memory response: one pulse per accepted request, reads and writes alike
- m_rdata  in  32  memory read data, valid with m_rvalid
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky; m_rvalid seen with no outstanding transaction

Behaviour:
- Reset: state IDLE; m_req, m_we, if_ready, d_ready, if_rvalid, d_rvalid, busy and protocol_err are all 0. m_addr, m_wdata, m_wstrb, if_rdata, d_rdata, owner and streak counter are all 0.
- FSM states: IDLE, ISSUE, WAIT.
- Arbitration happens in IDLE, or in WAIT on the cycle m_rvalid arrives:
  - d_req wins over if_req; otherwise if_req.
  - The winner's payload is registered into m_* and its identity into owner; next state is ISSUE.
  - If neither is requesting, next state is IDLE.
- ISSUE: m_req=1 and the m_* registers are held stable. When m_ready=1:
  - owner's x_ready=1 in the same cycle (combinational from m_ready and owner);
  - next state is WAIT, and m_req drops next cycle.
- WAIT: m_req=0. On m_rvalid:
  - m_rdata is registered into the owner's x_rdata;
  - the owner's x_rvalid pulses on the next cycle;
  - arbitration runs in the same cycle, so back-to-back issue is possible.
- Minimum latency, with req at cycle 0 and memory ready/rvalid on the earliest cycles:
  - m_req at cycle 1;
  - x_ready at cycle 1;
  - m_rvalid at cycle 2;
  - x_rvalid at cycle 3.
- A requester may present its next request from the cycle after x_ready. Requests still pending are never dropped.
- Stores return d_rvalid as an acknowledgement; d_rdata carries whatever the memory returned.
- For reads, m_wstrb is forced to 0000 and m_wdata to 0.
- m_rvalid in IDLE or ISSUE: ignored, and protocol_err is set until reset.
- Simultaneous if_req and d_req in IDLE: data is granted; fetch waits with if_ready=0.
- Reset mid-transaction: return to IDLE immediately. The in-flight response is dropped, and a late m_rvalid after reset sets protocol_err.
- x_rvalid never pulses for both requesters in the same cycle. if_ready and d_ready are never high together.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Enabled:
  - a 4-bit streak counter increments on each data grant made while if_req=1;
  - it clears on any fetch grant, or on a data grant made with if_req=0;
  - when streak == MAX_DATA_STREAK and if_req=1, the next grant goes to fetch even if d_req=1.
- Disabled: strict data priority, with no counter logic present.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, m_ready=1, m_rdata=0x00500093 -> if_ready at cycle 1, m_addr=0x100 and m_we=0, if_rvalid at cycle 3 with if_rdata=0x00500093.
- Store then load: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=1111, then a load from 0x2000 -> m_wstrb=1111 then 0000, two d_rvalid pulses, second with d_rdata=0xDEADBEEF.
- Contention: if_req and d_req both asserted in IDLE -> data granted first, fetch granted at the arbitration following the data m_rvalid; no ready or rvalid ever overlaps.
- Backpressure: m_ready=0 for 5 cycles in ISSUE -> m_req and m_addr held stable, x_ready stays 0 until m_ready=1.
- Error/reset: m_rvalid pulsed in IDLE -> protocol_err=1 sticky. reset asserted in WAIT -> IDLE next cycle and all outputs back to reset values.
- Fairness (macro on, MAX_DATA_STREAK=4): d_req and if_req held continuously -> grants D,D,D,D,F,D,… Macro off -> only D grants while d_req=1.
